// File: rtl/aes_kat_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : aes_kat_sequencer
// Purpose  : Hardware AES known-answer self-test. Walks a vector ROM, issues
//            encrypt/decrypt jobs to one iterative AES core, tallies results.
// Revision : 1.0 - initial release
// =============================================================================
module aes_kat_sequencer #(
  parameter int         NUM_VEC   = 2,
  parameter logic [2:0] MODE_EN   = 3'b111,
  parameter bit         DEC_CHECK = 1'b1,
  parameter int         TIMEOUT   = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [7:0]   vec_idx,
  input  logic [127:0] rom_in,
  input  logic [255:0] rom_key,
  input  logic [127:0] rom_exp128,
  input  logic [127:0] rom_exp192,
  input  logic [127:0] rom_exp256,
  output logic         core_start,
  output logic [1:0]   core_mode,
  output logic         core_dir,
  output logic [127:0] core_data,
  output logic [255:0] core_key,
  input  logic         core_done,
  input  logic [127:0] core_result,
  output logic [7:0]   pass_cnt,
  output logic [7:0]   fail_cnt,
  output logic [11:0]  first_fail,
  output logic         timeout_err
);

  localparam logic [2:0]  c_IDLE     = 3'd0;
  localparam logic [2:0]  c_FETCH    = 3'd1;
  localparam logic [2:0]  c_ISSUE    = 3'd2;
  localparam logic [2:0]  c_WAIT     = 3'd3;
  localparam logic [2:0]  c_CHECK    = 3'd4;
  localparam logic [2:0]  c_FIN      = 3'd5;
  localparam logic [7:0]  c_LAST_VEC = 8'(NUM_VEC - 1);
  localparam logic [15:0] c_TO_LAST  = 16'(TIMEOUT - 1);

  logic [2:0]   r_state;
  logic         r_busy, r_done, r_pass, r_core_start, r_dir, r_timeout_err;
  logic [1:0]   r_mode;
  logic [7:0]   r_vec, r_pass_cnt, r_fail_cnt;
  logic [11:0]  r_first_fail;
  logic [15:0]  r_timer;
  logic [127:0] r_core_data, r_ref, r_result;
  logic [255:0] r_core_key;

  logic [127:0] w_rom_exp;
  logic         w_first_ok, w_next_ok, w_adv_dir;
  logic [1:0]   w_first_mode, w_next_mode, w_adv_mode;
  logic [2:0]   w_adv_state;
  logic [7:0]   w_adv_vec, w_pass_inc, w_fail_inc;
  logic [11:0]  w_first_fail;

  always_comb begin
    case (r_mode)
      2'd0:    w_rom_exp = rom_exp128;
      2'd1:    w_rom_exp = rom_exp192;
      default: w_rom_exp = rom_exp256;
    endcase
  end

  // Mode walk order is 128 -> 192 -> 256, skipping any disabled key size.
  always_comb begin
    w_first_ok   = |MODE_EN;
    w_first_mode = MODE_EN[0] ? 2'd0 : (MODE_EN[1] ? 2'd1 : 2'd2);
    w_next_ok    = 1'b0;
    w_next_mode  = 2'd2;
    case (r_mode)
      2'd0: begin
        w_next_ok   = MODE_EN[1] | MODE_EN[2];
        w_next_mode = MODE_EN[1] ? 2'd1 : 2'd2;
      end
      2'd1:    w_next_ok = MODE_EN[2];
      default: w_next_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_adv_state = c_ISSUE;
    w_adv_mode  = r_mode;
    w_adv_dir   = 1'b0;
    w_adv_vec   = r_vec;
    if (DEC_CHECK && !r_dir) begin
      w_adv_dir = 1'b1;
    end else if (w_next_ok) begin
      w_adv_mode = w_next_mode;
    end else if (r_vec == c_LAST_VEC) begin
      w_adv_state = c_FIN;
    end else begin
      w_adv_vec   = r_vec + 8'd1;
      w_adv_state = c_FETCH;
    end
  end

  assign w_pass_inc   = (r_pass_cnt == 8'hFF) ? r_pass_cnt : r_pass_cnt + 8'd1;
  assign w_fail_inc   = (r_fail_cnt == 8'hFF) ? r_fail_cnt : r_fail_cnt + 8'd1;
  assign w_first_fail = r_first_fail[0] ? r_first_fail : {r_vec, r_mode, r_dir, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_core_start  <= 1'b0;
      r_dir         <= 1'b0;
      r_timeout_err <= 1'b0;
      r_mode        <= 2'd0;
      r_vec         <= 8'd0;
      r_pass_cnt    <= 8'd0;
      r_fail_cnt    <= 8'd0;
      r_first_fail  <= 12'd0;
      r_timer       <= 16'd0;
      r_core_data   <= '0;
      r_ref         <= '0;
      r_result      <= '0;
      r_core_key    <= '0;
    end else begin
      r_core_start <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_pass_cnt    <= 8'd0;
            r_fail_cnt    <= 8'd0;
            r_first_fail  <= 12'd0;
            r_timeout_err <= 1'b0;
            r_pass        <= 1'b0;
            r_vec         <= 8'd0;
            r_busy        <= 1'b1;
            r_state       <= c_FETCH;
          end
        end
        c_FETCH: begin
          r_mode  <= w_first_mode;
          r_dir   <= 1'b0;
          r_state <= w_first_ok ? c_ISSUE : c_FIN;
        end
        c_ISSUE: begin
          r_core_data  <= r_dir ? w_rom_exp : rom_in;
          r_ref        <= r_dir ? rom_in : w_rom_exp;
          r_core_key   <= rom_key;
          r_core_start <= 1'b1;
          r_timer      <= 16'd0;
          r_state      <= c_WAIT;
        end
        c_WAIT: begin
          if (core_done) begin
            r_result <= core_result;
            r_state  <= c_CHECK;
          end else if (r_timer == c_TO_LAST) begin
            r_fail_cnt    <= w_fail_inc;
            r_first_fail  <= w_first_fail;
            r_timeout_err <= 1'b1;
            r_state       <= w_adv_state;
            r_mode        <= w_adv_mode;
            r_dir         <= w_adv_dir;
            r_vec         <= w_adv_vec;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        c_CHECK: begin
          if (r_result == r_ref) begin
            r_pass_cnt <= w_pass_inc;
          end else begin
            r_fail_cnt   <= w_fail_inc;
            r_first_fail <= w_first_fail;
          end
          r_state <= w_adv_state;
          r_mode  <= w_adv_mode;
          r_dir   <= w_adv_dir;
          r_vec   <= w_adv_vec;
        end
        c_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_pass  <= (r_fail_cnt == 8'd0);
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign vec_idx     = r_vec;
  assign core_start  = r_core_start;
  assign core_mode   = r_mode;
  assign core_dir    = r_dir;
  assign core_data   = r_core_data;
  assign core_key    = r_core_key;
  assign pass_cnt    = r_pass_cnt;
  assign fail_cnt    = r_fail_cnt;
  assign first_fail  = r_first_fail;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_kat_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_aes_kat_sequencer
// Purpose  : Directed bench for aes_kat_sequencer with a table-driven ideal core.
// Revision : 1.0 - initial release
// =============================================================================
module tb_aes_kat_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start_w [4];
  logic         busy_w [4], done_w [4], pass_w [4], cs_w [4], cd_w [4], to_w [4];
  logic [7:0]   vec_w [4], pc_w [4], fc_w [4];
  logic [1:0]   cm_w [4];
  logic [127:0] cdata_w [4];
  logic [255:0] ckey_w [4];
  logic [11:0]  ff_w [4];

  logic [127:0] rom_in_s, rom_e128_s, rom_e192_s, rom_e256_s, core_result_s, m_res;
  logic [255:0] rom_key_s;
  logic         core_done_s, s_cs, s_cd, s_v;
  logic         m_done = 1'b0, m_pend = 1'b0, inj_done = 1'b0;
  logic [1:0]   s_cm;
  logic [127:0] s_cdata;
  logic [255:0] s_ckey;
  int           sel, cyc, m_jobs, m_bad, m_last, m_gap_drop, m_cnt, m_lat, m_drop_at;
  int           n_chk, n_err;

  // Golden vectors; the ROM serves g_in/g_key and a corruptible copy of g_exp.
  logic [127:0] g_in [2];
  logic [255:0] g_key [2];
  logic [127:0] g_exp [2][3];
  logic [127:0] r_exp_t [2][3];

  aes_kat_sequencer #(.NUM_VEC(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .vec_idx(vec_w[0]), .rom_in(rom_in_s), .rom_key(rom_key_s), .rom_exp128(rom_e128_s), .rom_exp192(rom_e192_s),
    .rom_exp256(rom_e256_s), .core_start(cs_w[0]), .core_mode(cm_w[0]), .core_dir(cd_w[0]), .core_data(cdata_w[0]),
    .core_key(ckey_w[0]), .core_done(core_done_s), .core_result(core_result_s), .pass_cnt(pc_w[0]),
    .fail_cnt(fc_w[0]), .first_fail(ff_w[0]), .timeout_err(to_w[0]));

  aes_kat_sequencer #(.NUM_VEC(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .vec_idx(vec_w[1]), .rom_in(rom_in_s), .rom_key(rom_key_s), .rom_exp128(rom_e128_s), .rom_exp192(rom_e192_s),
    .rom_exp256(rom_e256_s), .core_start(cs_w[1]), .core_mode(cm_w[1]), .core_dir(cd_w[1]), .core_data(cdata_w[1]),
    .core_key(ckey_w[1]), .core_done(core_done_s), .core_result(core_result_s), .pass_cnt(pc_w[1]),
    .fail_cnt(fc_w[1]), .first_fail(ff_w[1]), .timeout_err(to_w[1]));

  aes_kat_sequencer #(.NUM_VEC(2), .MODE_EN(3'b100), .DEC_CHECK(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .vec_idx(vec_w[2]), .rom_in(rom_in_s), .rom_key(rom_key_s), .rom_exp128(rom_e128_s), .rom_exp192(rom_e192_s),
    .rom_exp256(rom_e256_s), .core_start(cs_w[2]), .core_mode(cm_w[2]), .core_dir(cd_w[2]), .core_data(cdata_w[2]),
    .core_key(ckey_w[2]), .core_done(core_done_s), .core_result(core_result_s), .pass_cnt(pc_w[2]),
    .fail_cnt(fc_w[2]), .first_fail(ff_w[2]), .timeout_err(to_w[2]));

  aes_kat_sequencer #(.NUM_VEC(2), .MODE_EN(3'b000)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_w[3]), .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]),
    .vec_idx(vec_w[3]), .rom_in(rom_in_s), .rom_key(rom_key_s), .rom_exp128(rom_e128_s), .rom_exp192(rom_e192_s),
    .rom_exp256(rom_e256_s), .core_start(cs_w[3]), .core_mode(cm_w[3]), .core_dir(cd_w[3]), .core_data(cdata_w[3]),
    .core_key(ckey_w[3]), .core_done(core_done_s), .core_result(core_result_s), .pass_cnt(pc_w[3]),
    .fail_cnt(fc_w[3]), .first_fail(ff_w[3]), .timeout_err(to_w[3]));

  assign s_v         = vec_w[sel][0];
  assign s_cs        = cs_w[sel];
  assign s_cm        = cm_w[sel];
  assign s_cd        = cd_w[sel];
  assign s_cdata     = cdata_w[sel];
  assign s_ckey      = ckey_w[sel];
  assign core_done_s = m_done | inj_done;

  // ROM with one cycle of read latency, addressed by the selected DUT.
  always @(posedge clk) begin
    rom_in_s   <= g_in[s_v];
    rom_key_s  <= g_key[s_v];
    rom_e128_s <= r_exp_t[s_v][0];
    rom_e192_s <= r_exp_t[s_v][1];
    rom_e256_s <= r_exp_t[s_v][2];
  end

  // Ideal core: answers from the golden table; unknown inputs yield ~data.
  function automatic logic [127:0] oracle(input logic [1:0] mode, input logic dir,
                                          input logic [127:0] d, input logic [255:0] k);
    for (int v = 0; v < 2; v++) begin
      if (k == g_key[v]) begin
        if (!dir && d == g_in[v]) return g_exp[v][mode];
        if (dir && d == g_exp[v][mode]) return g_in[v];
      end
    end
    return ~d;
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_done <= 1'b0;
    if (m_pend) begin
      if (m_cnt == 0) begin
        m_done        <= 1'b1;
        core_result_s <= m_res;
        m_pend        <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
    if (s_cs) begin
      m_jobs <= m_jobs + 1;
      m_last <= cyc;
      if (m_jobs + 1 == m_drop_at + 1) m_gap_drop <= cyc - m_last;
      if (s_cm != 2'd2 || s_cd) m_bad <= m_bad + 1;
      if (m_jobs + 1 != m_drop_at) begin
        if (m_lat <= 1) begin
          m_done        <= 1'b1;
          core_result_s <= oracle(s_cm, s_cd, s_cdata, s_ckey);
        end else begin
          m_pend <= 1'b1;
          m_cnt  <= m_lat - 2;
          m_res  <= oracle(s_cm, s_cd, s_cdata, s_ckey);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_w[sel] = 1'b1;
    @(posedge clk); #1 start_w[sel] = 1'b0;
    chk("busy_after_start", {31'd0, busy_w[sel]}, 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk); #1;
      if (done_w[sel]) begin
        n = i;
        break;
      end
    end
    chk("done_seen", {31'd0, n != 0}, 32'd1);
  endtask

  initial begin
    int base, bbase, n;
    logic seen;
    for (int i = 0; i < 4; i++) start_w[i] = 1'b0;
    g_in[0]     = 128'h00112233445566778899aabbccddeeff;
    g_in[1]     = 128'h32431238feca308d317908a2eb3ff224;
    g_key[0]    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    g_key[1]    = g_key[0];
    g_exp[0][0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    g_exp[0][1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    g_exp[0][2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    g_exp[1][0] = 128'h2b193424d8de4648e598dcf7d78504dd;
    g_exp[1][1] = 128'h5a4b3c2d1e0f11223344556677889900;
    g_exp[1][2] = 128'hc0ffee00deadbeef0123456789abcdef;
    r_exp_t     = g_exp;
    m_lat       = 3;
    m_drop_at   = 0;
    sel         = 1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", {31'd0, busy_w[1]}, 32'd0);
    chk("rst_done", {31'd0, done_w[1]}, 32'd0);
    chk("rst_pass", {31'd0, pass_w[1]}, 32'd0);
    chk("rst_pass_cnt", {24'd0, pc_w[1]}, 32'd0);
    chk("rst_fail_cnt", {24'd0, fc_w[1]}, 32'd0);
    chk("rst_first_fail", {20'd0, ff_w[1]}, 32'd0);
    chk("rst_timeout_err", {31'd0, to_w[1]}, 32'd0);
    chk("rst_core_start", {31'd0, cs_w[1]}, 32'd0);

    // One vector, all modes both directions.
    sel = 0; base = m_jobs;
    pulse_start(); wait_done(n);
    chk("t1_jobs", 32'(m_jobs - base), 32'd6);
    chk("t1_pass_cnt", {24'd0, pc_w[0]}, 32'd6);
    chk("t1_fail_cnt", {24'd0, fc_w[0]}, 32'd0);
    chk("t1_pass", {31'd0, pass_w[0]}, 32'd1);
    chk("t1_first_fail", {20'd0, ff_w[0]}, 32'd0);
    chk("t1_busy_end", {31'd0, busy_w[0]}, 32'd0);

    // Second vector with a corrupted 192-bit expectation.
    sel = 1; r_exp_t[1][1] = g_exp[1][1] ^ 128'h1;
    pulse_start(); wait_done(n);
    chk("t2_pass_cnt", {24'd0, pc_w[1]}, 32'd10);
    chk("t2_fail_cnt", {24'd0, fc_w[1]}, 32'd2);
    chk("t2_first_fail", {20'd0, ff_w[1]}, 32'h015);
    chk("t2_pass", {31'd0, pass_w[1]}, 32'd0);
    chk("t2_timeout_err", {31'd0, to_w[1]}, 32'd0);
    r_exp_t[1][1] = g_exp[1][1];

    // Core swallows job 3; next job issues 64 WAIT cycles + 1 ISSUE cycle later.
    m_drop_at = m_jobs + 3;
    pulse_start(); wait_done(n);
    chk("t3_timeout_err", {31'd0, to_w[1]}, 32'd1);
    chk("t3_fail_cnt", {24'd0, fc_w[1]}, 32'd1);
    chk("t3_pass_cnt", {24'd0, pc_w[1]}, 32'd11);
    chk("t3_pass", {31'd0, pass_w[1]}, 32'd0);
    chk("t3_gap", 32'(m_gap_drop), 32'd65);
    m_drop_at = 0;

    // AES-256 encrypt only.
    sel = 2; base = m_jobs; bbase = m_bad;
    pulse_start(); wait_done(n);
    chk("t4_jobs", 32'(m_jobs - base), 32'd2);
    chk("t4_bad_jobs", 32'(m_bad - bbase), 32'd0);
    chk("t4_pass_cnt", {24'd0, pc_w[2]}, 32'd2);
    chk("t4_pass", {31'd0, pass_w[2]}, 32'd1);

    // No modes enabled: done three cycles after the start cycle.
    sel = 3; base = m_jobs;
    pulse_start(); wait_done(n);
    chk("t4_empty_latency", 32'(n), 32'd2);
    chk("t4_empty_pass", {31'd0, pass_w[3]}, 32'd1);
    chk("t4_empty_jobs", 32'(m_jobs - base), 32'd0);

    // Reset while waiting on the fourth job.
    sel = 1; base = m_jobs; seen = 1'b0;
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (m_jobs - base >= 3 && cs_w[1]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t5_reached_wait", {31'd0, seen}, 32'd1);
    chk("t5_pre_pass_cnt", {24'd0, pc_w[1]}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", {31'd0, busy_w[1]}, 32'd0);
    chk("t5_pass_cnt", {24'd0, pc_w[1]}, 32'd0);
    chk("t5_core_start", {31'd0, cs_w[1]}, 32'd0);
    chk("t5_core_data_zero", {31'd0, cdata_w[1] == 128'd0}, 32'd1);
    chk("t5_core_mode", {30'd0, cm_w[1]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen = seen | done_w[1];
    end
    chk("t5_no_done", {31'd0, seen}, 32'd0);

    // Latency 1, with a second start while busy.
    m_lat = 1; base = m_jobs;
    pulse_start();
    repeat (6) @(posedge clk);
    pulse_start(); wait_done(n);
    chk("t6_jobs", 32'(m_jobs - base), 32'd12);
    chk("t6_pass_cnt", {24'd0, pc_w[1]}, 32'd12);
    chk("t6_fail_cnt", {24'd0, fc_w[1]}, 32'd0);
    chk("t6_pass", {31'd0, pass_w[1]}, 32'd1);

    // Spurious core_done in IDLE.
    @(posedge clk); #1 inj_done = 1'b1;
    @(posedge clk); #1 inj_done = 1'b0;
    @(posedge clk); #1;
    chk("t6_idle_spur_pass_cnt", {24'd0, pc_w[1]}, 32'd12);
    chk("t6_idle_spur_fail_cnt", {24'd0, fc_w[1]}, 32'd0);

    // Latency TIMEOUT-2, with a spurious core_done during FETCH.
    m_lat = 62;
    pulse_start();
    inj_done = 1'b1;
    @(posedge clk); #1 inj_done = 1'b0;
    wait_done(n);
    chk("t6_slow_pass_cnt", {24'd0, pc_w[1]}, 32'd12);
    chk("t6_slow_fail_cnt", {24'd0, fc_w[1]}, 32'd0);
    chk("t6_slow_timeout_err", {31'd0, to_w[1]}, 32'd0);
    chk("t6_slow_pass", {31'd0, pass_w[1]}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
